// File: rtl/led_pkg.sv
// Shared constants and FSM state type for the RGB LED scheduler.
package led_pkg;

    localparam int       NUM_REQ = 4;
    localparam logic [2:0] LED_OFF = 3'b111;
    localparam logic [2:0] GREEN   = 3'b110;
    localparam logic [2:0] RED     = 3'b101;
    localparam logic [2:0] BLUE    = 3'b011;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

endpackage

// File: rtl/led_rr_pick.sv
// Combinational round-robin picker: first requester with req high,
// searching upward from (last_ptr+1) mod 4.
module led_rr_pick
    import led_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last_ptr,
    output logic [1:0]         winner,
    output logic               valid
);

    logic [1:0] idx;

    always_comb begin
        valid  = 1'b0;
        winner = 2'd0;
        idx    = 2'd0;
        // i = NUM_REQ wraps back to last_ptr itself, so a lone requester re-wins.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last_ptr + 2'(i);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/led_sched.sv
// Time-slotted round-robin scheduler sharing one active-low RGB LED among
// four requesters; grant, led and busy are registered outputs.
module led_sched
    import led_pkg::*;
#(
    parameter logic [23:0] SLOT_CYCLES = 24'd12_000_000
)
(
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [3*NUM_REQ-1:0] color,
    input  logic [NUM_REQ-1:0]   blink,
    output logic [NUM_REQ-1:0]   grant,
    output logic [2:0]           led,
    output logic                 busy
);

    localparam logic [23:0] SLOT_LAST = SLOT_CYCLES - 24'd1;
    localparam logic [23:0] SLOT_HALF = SLOT_CYCLES / 24'd2;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [2:0]           led_q, led_d;
    logic                 busy_q, busy_d;
    logic [23:0]          cnt_q, cnt_d;
    logic [1:0]           last_q, last_d;
    logic [2:0]           col_q, col_d;
    logic                 blink_q, blink_d;
    logic                 armed_q;

    logic [1:0]           pick_idx;
    logic                 pick_valid;
    logic [2:0]           pick_col;
    logic                 take;

    led_rr_pick u_pick (
        .req      (req),
        .last_ptr (last_q),
        .winner   (pick_idx),
        .valid    (pick_valid)
    );

    always_comb begin
        pick_col = LED_OFF;
        case (pick_idx)
            2'd0: pick_col = color[2:0];
            2'd1: pick_col = color[5:3];
            2'd2: pick_col = color[8:6];
            2'd3: pick_col = color[11:9];
            default: pick_col = LED_OFF;
        endcase
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        col_d   = col_q;
        blink_d = blink_q;
        take    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d   = 24'd0;
                grant_d = '0;
                take    = armed_q && pick_valid;
            end
            SHOW: begin
                // last_q always names the current owner while in SHOW.
                if (cnt_q == SLOT_LAST || !req[last_q]) begin
                    if (pick_valid) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        cnt_d   = 24'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = 24'd0;
            end
        endcase

        if (take) begin
            state_d = SHOW;
            grant_d = 4'b0001 << pick_idx;
            cnt_d   = 24'd0;
            last_d  = pick_idx;
            col_d   = pick_col;
            blink_d = blink[pick_idx];
        end

        // Outputs are computed from next state so they line up with the counter.
        if (state_d == SHOW) begin
            led_d = (blink_d && cnt_d >= SLOT_HALF) ? LED_OFF : col_d;
        end else begin
            led_d = LED_OFF;
        end
        busy_d = (state_d == SHOW);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            led_q   <= LED_OFF;
            busy_q  <= 1'b0;
            cnt_q   <= 24'd0;
            last_q  <= 2'd3;
            col_q   <= LED_OFF;
            blink_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            col_q   <= col_d;
            blink_q <= blink_d;
            // Holds off the first grant until the second edge after reset release.
            armed_q <= 1'b1;
        end
    end

    // busy mirrors the FSM state (high exactly in SHOW).
    assign grant = grant_q;
    assign led   = led_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_led_sched.sv
// Self-checking bench for led_sched with SLOT_CYCLES=8: directed scenarios
// plus randomized traffic against a slot-level reference model.
module tb_led_sched;

    localparam int SLOT = 8;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [3:0]  req;
    logic [11:0] color;
    logic [3:0]  blink;
    logic [3:0]  grant;
    logic [2:0]  led;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    // Reference model: who owns the LED, how long they have held it,
    // and what pattern they were granted with.
    int         m_owner;
    int         m_age;
    int         m_last;
    logic [2:0] m_col;
    logic       m_blink;
    bit         m_armed;

    led_sched #(.SLOT_CYCLES(24'd8)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req       (req),
        .color     (color),
        .blink     (blink),
        .grant     (grant),
        .led       (led),
        .busy      (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_last  = 3;
        m_col   = 3'b111;
        m_blink = 1'b0;
        m_armed = 1'b0;
    endtask

    function automatic logic [7:0] model_outputs();
        logic [3:0] g;
        logic [2:0] l;
        if (m_owner < 0) begin
            g = 4'b0000;
            l = 3'b111;
        end else begin
            g = 4'b0001 << m_owner;
            l = (m_blink && m_age >= SLOT / 2) ? 3'b111 : m_col;
        end
        return {g, l, (m_owner >= 0)};
    endfunction

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        bit rearb;
        int w;
        int c;
        if (m_owner < 0) rearb = m_armed;
        else             rearb = (m_age == SLOT - 1) || !req[m_owner];
        if (rearb) begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
                c = (m_last + k) % 4;
                if (w < 0 && req[c]) w = c;
            end
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_age   = 0;
                m_col   = color[w*3 +: 3];
                m_blink = blink[w];
            end else begin
                m_owner = -1;
                m_age   = 0;
            end
        end else if (m_owner >= 0) begin
            m_age++;
        end
        m_armed = 1'b1;
    endtask

    task automatic step(input string tag);
        logic [7:0] e;
        model_edge();
        exp_q.push_back(model_outputs());
        @(posedge sys_clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".grant"}, 32'(grant), 32'(e[7:4]));
        check({tag, ".led"},   32'(led),   32'(e[3:1]));
        check({tag, ".busy"},  32'(busy),  32'(e[0]));
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Asynchronous reset pulse between edges; outputs must drop before any clock.
    task automatic reset_pulse(input string tag);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check({tag, ".rst_grant"}, 32'(grant), 32'h0);
        check({tag, ".rst_led"},   32'(led),   32'h7);
        check({tag, ".rst_busy"},  32'(busy),  32'h0);
        model_reset();
        #1;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        req   = 4'b0000;
        color = 12'hfff;
        blink = 4'b0000;
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        check("reset.grant", 32'(grant), 32'h0);
        check("reset.led",   32'(led),   32'h7);
        check("reset.busy",  32'(busy),  32'h0);
        #3;
        sys_rst_n = 1'b1;

        // Requester 0 alone: granted, then regranted back-to-back.
        step("arm");
        req   = 4'b0001;
        color = {3'b111, 3'b111, 3'b111, 3'b110};
        step("first_grant");
        check("first_grant.direct", 32'(grant), 32'h1);
        steps("solo0", 20);

        // All four requesting: strict rotation.
        req   = 4'b1111;
        color = {3'b011, 3'b101, 3'b110, 3'b011};
        steps("all4", 5 * SLOT);

        // Blinking owner 2.
        req   = 4'b0000;
        steps("drain1", SLOT + 1);
        req   = 4'b0100;
        color = {3'b111, 3'b101, 3'b111, 3'b111};
        blink = 4'b0100;
        steps("blink2", 2 * SLOT + 2);

        // Owner 1 releases early while requester 3 waits.
        req   = 4'b0000;
        blink = 4'b0000;
        steps("drain2", 2);
        req   = 4'b0010;
        color = {3'b011, 3'b111, 3'b101, 3'b111};
        step("own1");
        check("own1.direct", 32'(grant), 32'h2);
        req = 4'b1010;
        steps("hold1", 3);
        req = 4'b1000;
        step("early_release");
        check("early_release.direct", 32'(grant), 32'h8);
        req = 4'b0000;
        steps("to_idle", 2);
        check("to_idle.direct_busy", 32'(busy), 32'h0);

        // Reset mid-slot with owner 2, then restart priority from requester 0.
        req   = 4'b0100;
        color = {3'b111, 3'b101, 3'b111, 3'b111};
        steps("own2", 4);
        reset_pulse("mid_slot");
        req = 4'b0110;
        step("post_rst_arm");
        step("post_rst_grant");
        check("post_rst_grant.direct", 32'(grant), 32'h2);
        steps("post_rst_run", SLOT);

        // Color change from the owner is ignored until the next grant.
        req   = 4'b0000;
        steps("drain3", SLOT + 1);
        req   = 4'b0001;
        color = {3'b111, 3'b111, 3'b111, 3'b110};
        steps("col_a", 3);
        color = {3'b111, 3'b111, 3'b111, 3'b011};
        steps("col_b", SLOT + 2);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) color = 12'($urandom);
            if ($urandom_range(0, 7) == 0) blink = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) reset_pulse("rand");
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_sched.md
LED_SCHED -- requirements
Module: led_sched

Interface
REQ-001 Parameter SLOT_CYCLES, default 24'd12_000_000, slot length in clocks (0.5 s at 24 MHz); legal range 2..2^24-1.
REQ-002 sys_clk  input  1  single clock; all state on rising edge.
REQ-003 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  per-requester request for the RGB LED; level, held while wanted.
REQ-005 color  input  12  per-requester pattern, color[3i+2:3i]; active-low RGB (110 G, 101 R, 011 B).
REQ-006 blink  input  4  per-requester blink enable.
REQ-007 grant  output  4  one-hot owner of the LED; all-zero when idle; registered.
REQ-008 led  output  3  active-low RGB LED drive; registered.
REQ-009 busy  output  1  high while in SHOW; registered.

Function
REQ-010 FSM states: IDLE, SHOW.
REQ-011 IDLE: grant=0, led=3'b111, busy=0; the slot counter holds at 0.
REQ-012 IDLE with any req high: the next edge enters SHOW, sets grant to the round-robin winner, latches that requester's color and blink, and clears the slot counter; one-cycle latency from req to grant/led.
REQ-013 Round-robin winner: the first requester with req high, searching upward from (last_ptr+1) mod 4; last_ptr updates to the winner on every grant.
REQ-014 SHOW: the 24-bit slot counter increments by 1 each clock, from 0 to SLOT_CYCLES-1.
REQ-015 SHOW led: the latched color when latched blink=0; with blink=1, the latched color while counter < SLOT_CYCLES/2 (integer divide), otherwise 3'b111.
REQ-016 Color and blink changes from the current owner during a slot are ignored until its next grant.
REQ-017 Slot end (counter==SLOT_CYCLES-1): if any req is high that cycle, the next edge grants the round-robin winner (same requester again if it is the only one), reloads color and blink, and zeroes the counter with no idle gap; otherwise it returns to IDLE.
REQ-018 Early release: if the owner's req is low in SHOW before slot end, the next edge rearbitrates as at slot end (same rules as REQ-017).
REQ-019 A req from a non-owner during SHOW never preempts; it waits for slot end or early release.
REQ-020 Simultaneous owner drop and slot end: one rearbitration only; no double advance of last_ptr.
REQ-021 grant is always one-hot or zero; led=3'b111 whenever grant=0.
REQ-022 The counter never exceeds SLOT_CYCLES-1 and never wraps in normal operation.

Reset
REQ-023 On sys_rst_n low, asynchronously and regardless of state: state=IDLE, grant=4'b0000, led=3'b111, busy=0, counter=0, last_ptr=3 (requester 0 has first priority), latched color=3'b111, latched blink=0.
REQ-024 Reset asserted mid-slot drops the LED to 3'b111 immediately; after release, arbitration restarts from requester 0.
REQ-025 The first grant after reset release occurs no earlier than the second rising edge after deassertion.

Structure
REQ-026 Shared package led_pkg holds: NUM_REQ=4, LED_OFF=3'b111, the color constants (GREEN=3'b110, RED=3'b101, BLUE=3'b011), and the FSM state type (IDLE, SHOW).
REQ-027 One combinational sub-module, led_rr_pick (inputs: req[3:0], last_ptr[1:0]; outputs: winner index, valid), implements REQ-013; all registers stay in led_sched.

Verification (bench uses SLOT_CYCLES=8)
REQ-028 Reset, then req=4'b0001 with color0=110 and blink0=0 -> grant=0001 and led=110 one cycle later; grant held for 8 cycles, then regranted to requester 0 with no gap.
REQ-029 req=4'b1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001, each lasting exactly 8 cycles.
REQ-030 Owner 2 with blink2=1 and color2=101 -> led=101 for counter 0..3 and 111 for counter 4..7, repeating each slot.
REQ-031 Owner 1 drops req at counter=3 while req3 is high -> grant=1000 on the next edge and the counter restarts at 0; with no other req pending -> IDLE, led=111, busy=0.
REQ-032 sys_rst_n pulsed low mid-slot with owner 2 -> led=111 and grant=0 without waiting for a clock edge; after release with req=4'b0110 -> requester 1 wins first.
REQ-033 Owner 0 changes color0 from 110 to 011 mid-slot -> led stays 110 until slot end, then shows 011 on regrant.
